prog_loader: RTL

- Host-side writer for the program store. The CPU bootloader reads this store sequentially from address 0 at power-up.
- Accepts a byte stream over a valid/ready handshake and writes it into the parallel EEPROM with correct CE/WE/OE timing.
- Holds the CPU in reset for the whole load, then releases it so the bootloader copies the new image into RAM.

---
 rtl/prog_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
`timescale 1ns / 1ps
// Program-store writer: takes a byte stream over valid/ready and programs a parallel EEPROM
// from address 0, holding the CPU in reset until the image is complete.
module prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned WC_CYCLES = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ee_addr,
    output logic [7:0]        ee_data,
    output logic              ee_data_oe,
    output logic              ee_ce_bar,
    output logic              ee_we_bar,
    output logic              ee_oe_bar,
    output logic              cpu_rst_bar,
    output logic              busy,
    output logic              done,
    output logic              truncated,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);
    localparam int unsigned CntMax = (WC_CYCLES > WE_CYCLES) ? WC_CYCLES : WE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam logic [CntW-1:0]   WeLast   = CntW'(WE_CYCLES - 1);
    localparam logic [CntW-1:0]   WcLast   = CntW'(WC_CYCLES - 1);
    localparam logic [CntW-1:0]   CntOne   = CntW'(1);
    localparam logic [ADDR_W-1:0] AddrMax  = '1;
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle, StAccept, StSetup, StPulse, StHold, StWait, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        cksum_q, cksum_d;
    logic              trunc_q, trunc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            cksum_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            cksum_q <= cksum_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_d      = last_q;
        count_d     = count_q;
        cksum_d     = cksum_q;
        trunc_d     = trunc_q;
        in_ready    = 1'b0;
        ee_data_oe  = 1'b0;
        ee_ce_bar   = 1'b1;
        ee_we_bar   = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;
        cpu_rst_bar = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                busy = 1'b0;
                if (state_q == StDone) begin
                    done        = 1'b1;
                    cpu_rst_bar = 1'b1;
                end
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    cksum_d = '0;
                    trunc_d = 1'b0;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    cksum_d = cksum_q + in_data;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                ee_ce_bar  = 1'b0;
                ee_data_oe = 1'b1;
                cnt_d      = '0;
                state_d    = StPulse;
            end
            StPulse: begin
                ee_ce_bar  = 1'b0;
                ee_we_bar  = 1'b0;
                ee_data_oe = 1'b1;
                if (cnt_q == WeLast) state_d = StHold;
                else                 cnt_d   = cnt_q + CntOne;
            end
            StHold: begin
                // Data stays driven one cycle past the WE rising edge.
                ee_ce_bar  = 1'b0;
                ee_data_oe = 1'b1;
                cnt_d      = '0;
                count_d    = count_q + CountOne;
                state_d    = StWait;
            end
            StWait: begin
                if (cnt_q != WcLast) begin
                    cnt_d = cnt_q + CntOne;
                end else if (last_q) begin
                    state_d = StDone;
                end else if (addr_q == AddrMax) begin
                    trunc_d = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + AddrOne;
                    state_d = StAccept;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ee_addr    = addr_q;
    assign ee_data    = data_q;
    assign ee_oe_bar  = 1'b1;
    assign truncated  = trunc_q;
    assign byte_count = count_q;
    assign checksum   = cksum_q;

endmodule
